// File: rtl/led_scan_capture.sv
// Rebuilds complete 8x8 RGB frames from a row-multiplexed LED matrix scan.
// Flags out-of-order rows and reports whether each committed frame differs from the previous one.
module led_scan_capture #(
  parameter int MIN_DWELL = 4,
  parameter bit INVERT    = 1'b0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        scan_en,
  input  logic [2:0]  scan_com,
  input  logic [7:0]  scan_red,
  input  logic [7:0]  scan_green,
  input  logic [7:0]  scan_blue,
  output logic [63:0] red_frame,
  output logic [63:0] green_frame,
  output logic [63:0] blue_frame,
  output logic        frame_valid,
  output logic        frame_changed,
  output logic        seq_err,
  output logic [7:0]  frame_count
);

  localparam int DW = $clog2(MIN_DWELL + 1);

  typedef enum logic {SYNC, ASSEMBLE} state_t;

  state_t        state, state_n;
  logic [2:0]    next_row, next_row_n;
  logic          s_en;
  logic [2:0]    s_com, prev_com;
  logic [7:0]    s_red, s_green, s_blue;
  logic [DW-1:0] dwell, dwell_n;
  logic          com_stable, accept;
  logic          have_frame, have_frame_n;
  logic [63:0]   asm_red, asm_green, asm_blue;
  logic [63:0]   asm_red_n, asm_green_n, asm_blue_n;
  logic [63:0]   red_frame_n, green_frame_n, blue_frame_n;
  logic          frame_valid_n, frame_changed_n, seq_err_n;
  logic [7:0]    frame_count_n;

  // Scan bit 7 is column 0, while frame bit row*8+col grows with column.
  function automatic logic [7:0] bit_rev(input logic [7:0] b);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = b[7-i];
    return r;
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s_en     <= 1'b0;
      s_com    <= 3'd0;
      prev_com <= 3'd0;
      s_red    <= 8'd0;
      s_green  <= 8'd0;
      s_blue   <= 8'd0;
      dwell    <= '0;
    end else begin
      s_en     <= scan_en;
      s_com    <= scan_com;
      prev_com <= s_com;
      s_red    <= INVERT ? ~scan_red   : scan_red;
      s_green  <= INVERT ? ~scan_green : scan_green;
      s_blue   <= INVERT ? ~scan_blue  : scan_blue;
      dwell    <= dwell_n;
    end
  end

  // Accept fires only on the MIN_DWELL-1 -> MIN_DWELL step, so once per row visit.
  always_comb begin
    com_stable = s_en && (s_com == prev_com);
    accept     = com_stable && (dwell == DW'(MIN_DWELL - 1));
    dwell_n    = dwell;
    if (!com_stable)                     dwell_n = '0;
    else if (dwell != DW'(MIN_DWELL))    dwell_n = dwell + DW'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= SYNC;
      next_row      <= 3'd0;
      asm_red       <= 64'd0;
      asm_green     <= 64'd0;
      asm_blue      <= 64'd0;
      have_frame    <= 1'b0;
      red_frame     <= 64'd0;
      green_frame   <= 64'd0;
      blue_frame    <= 64'd0;
      frame_valid   <= 1'b0;
      frame_changed <= 1'b0;
      seq_err       <= 1'b0;
      frame_count   <= 8'd0;
    end else begin
      state         <= state_n;
      next_row      <= next_row_n;
      asm_red       <= asm_red_n;
      asm_green     <= asm_green_n;
      asm_blue      <= asm_blue_n;
      have_frame    <= have_frame_n;
      red_frame     <= red_frame_n;
      green_frame   <= green_frame_n;
      blue_frame    <= blue_frame_n;
      frame_valid   <= frame_valid_n;
      frame_changed <= frame_changed_n;
      seq_err       <= seq_err_n;
      frame_count   <= frame_count_n;
    end
  end

  always_comb begin
    state_n         = state;
    next_row_n      = next_row;
    asm_red_n       = asm_red;
    asm_green_n     = asm_green;
    asm_blue_n      = asm_blue;
    have_frame_n    = have_frame;
    red_frame_n     = red_frame;
    green_frame_n   = green_frame;
    blue_frame_n    = blue_frame;
    frame_valid_n   = 1'b0;
    frame_changed_n = 1'b0;
    seq_err_n       = 1'b0;
    frame_count_n   = frame_count;

    if (accept) begin
      // A row 0 always (re)starts a frame unless it is the expected row mid-frame.
      if (s_com == next_row || (state == SYNC && s_com == 3'd0) || s_com == 3'd0) begin
        asm_red_n[{s_com, 3'b000} +: 8]   = bit_rev(s_red);
        asm_green_n[{s_com, 3'b000} +: 8] = bit_rev(s_green);
        asm_blue_n[{s_com, 3'b000} +: 8]  = bit_rev(s_blue);
      end
      case (state)
        SYNC: begin
          if (s_com == 3'd0) begin
            next_row_n = 3'd1;
            state_n    = ASSEMBLE;
          end
        end
        ASSEMBLE: begin
          if (s_com == next_row) begin
            if (next_row == 3'd7) begin
              red_frame_n     = asm_red_n;
              green_frame_n   = asm_green_n;
              blue_frame_n    = asm_blue_n;
              frame_valid_n   = 1'b1;
              frame_changed_n = !have_frame ||
                                ({asm_red_n, asm_green_n, asm_blue_n} !=
                                 {red_frame, green_frame, blue_frame});
              frame_count_n   = frame_count + 8'd1;
              have_frame_n    = 1'b1;
              next_row_n      = 3'd0;
              state_n         = SYNC;
            end else begin
              next_row_n = next_row + 3'd1;
            end
          end else begin
            seq_err_n = 1'b1;
            if (s_com == 3'd0) begin
              next_row_n = 3'd1;
            end else begin
              next_row_n = 3'd0;
              state_n    = SYNC;
            end
          end
        end
        default: state_n = SYNC;
      endcase
    end
  end

endmodule
